dpr_w_i_reader: RTL and testbench
=================================

Name: dpr_w_i_reader

Overview:
- Read-side sequencer for the W_i dual-port weight RAM (dpr_w_i).
- On `start`, walks the gamma x m weight matrix stored at linear address `row*m + col` and drives the RAM read port (`address_out`, `cs_out`, `oe_out`).
- Captures `data_out` one cycle after each read and streams elements to the systolic array over a valid/ready handshake, with row and matrix end markers.
- Absorbs backpressure in a 2-entry output FIFO with credit-limited read issue, so no element is lost or duplicated.

Parameters:
- FEATURE_BITS, 4, width of `m` and `gamma`.
- ELEMENT_BITS, 8, weight element width.
- FIFO_DEPTH, 2, output buffer entries; minimum 2 for full throughput.

Ports:
- sys_clk  in  1  systolic array clock; all logic on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- m  in  FEATURE_BITS  columns per row (features); sampled on accepted `start`.
- gamma  in  FEATURE_BITS  number of rows; sampled on accepted `start`.
- start  in  1  pulse; begin a matrix read; honoured only in IDLE.
- busy  out  1  high from accepted start until done pulse.
- done  out  1  one-cycle pulse after the final element handshake.
- address_out  out  2*FEATURE_BITS  RAM read address.
- cs_out  out  1  RAM read-port chip select.
- oe_out  out  1  RAM output enable; equals `cs_out`.
- data_out  in  ELEMENT_BITS  RAM read data, valid the cycle after `cs_out` & `oe_out`.
- w_data  out  ELEMENT_BITS  weight element to the array.
- w_valid  out  1  `w_data` valid.
- w_ready  in  1  array accepts; handshake = `w_valid` & `w_ready`.
- w_row_last  out  1  element is the last of its inner-loop line.
- w_mat_last  out  1  element is the last of the matrix.

Behaviour:
- Reset (`reset_n`=0 at the edge):
  - FSM goes to IDLE; FIFO and counters clear.
  - All outputs 0 the next cycle, including `address_out`.
  - Applies mid-operation; outstanding reads are discarded.
- IDLE:
  - On `start`=1, latch `m` and `gamma`; row=col=0; `busy`=1; go to FETCH.
  - If latched `m`==0 or `gamma`==0, go to FINISH instead; no reads are issued.
- FETCH:
  - Each cycle, issue a read (`cs_out`=`oe_out`=1, `address_out`=current address) only if `occupancy + inflight - pop < FIFO_DEPTH`, where `pop` is this cycle's handshake.
  - Address is a 2*FEATURE_BITS counter starting at 0 and incrementing by 1 per issued read.
  - col wraps at m-1 to 0, and row then increments. The product m*gamma <= 225 fits the address width.
  - After the read of (gamma-1, m-1) is issued, go to DRAIN.
  - When no read is issued, `cs_out`=`oe_out`=0 and `address_out` holds its value.
- Capture:
  - `inflight` flag is set for the cycle after an issue.
  - `data_out` is pushed into the FIFO at the end of that cycle, together with `row_last` (col==m-1) and `mat_last` (last address) tags computed at issue.
- DRAIN: wait until the FIFO is empty and no read is in flight, then go to FINISH.
- FINISH: `done`=1 for one cycle; `busy`=0 from the next cycle; return to IDLE.
- Output side:
  - `w_valid` = FIFO not empty; `w_data` and the tags come from the FIFO head.
  - Head is stable while `w_valid` & !`w_ready`.
  - Push and pop in the same cycle are allowed, and occupancy is unchanged.
- Latency and throughput:
  - `start` sampled at cycle T; address 0 issued at T+1; first `w_valid` at T+3.
  - With `w_ready` held high, one element per cycle and no bubbles.
  - `done` follows the last handshake by 1 cycle.
- `start` while busy is ignored; latched m and gamma do not change.
- `m`=1: every element has `w_row_last`=1.

Optional Feature:
- Macro: DPR_W_I_READER_COL_MAJOR_EN.
- With the macro: extra input port `col_major` (1 bit), sampled on `start`.
  - When 1, traversal is column-major: the outer loop is col, the inner loop is row.
  - Address = `row*m + col`, computed with a running row-base register; no multiplier.
  - `w_row_last` then marks row==gamma-1.
- Without the macro: no port; row-major only; the address is a plain incrementer.

Test Plan:
- m=9, gamma=3, `w_ready`=1:
  - Addresses 0..26, consecutive cycles from T+1.
  - 27 beats, first `w_valid` at T+3.
  - `w_row_last` on beats 8, 17, 26; `w_mat_last` on beat 26.
  - `done` 1 cycle after beat 26; `w_data` matches the RAM contents in order.
- Same matrix, `w_ready` low for 5 cycles after beat 3:
  - `w_data` is stable during the stall.
  - At most 2 elements are buffered and `cs_out` idles when credits run out.
  - All 27 elements arrive exactly once, in order.
- m=0, gamma=3, `start`: `cs_out` never asserts; `done` pulses at T+2; `busy` is high for T+1..T+2 only.
- `start` re-pulsed at beat 5 with m=4: ignored; the run completes 27 beats with the original m=9.
- `reset_n`=0 for one cycle at beat 10: all outputs 0 next cycle. A new `start` restarts at address 0 with 27 fresh beats.
- (DPR_W_I_READER_COL_MAJOR_EN) m=3, gamma=2, `col_major`=1: address order 0,3,1,4,2,5; `w_row_last` on beats 1, 3, 5.

Source files
------------

// File: rtl/dpr_w_i_reader.sv
// Read-side sequencer for the W_i weight RAM: walks the gamma x m matrix, streams elements with row/matrix tags.
// Optional column-major traversal (adds port col_major) is enabled by defining DPR_W_I_READER_COL_MAJOR_EN.
module dpr_w_i_reader #(
  parameter int FEATURE_BITS = 4,
  parameter int ELEMENT_BITS = 8,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                      sys_clk,
  input  logic                      reset_n,
  input  logic [FEATURE_BITS-1:0]   m,
  input  logic [FEATURE_BITS-1:0]   gamma,
`ifdef DPR_W_I_READER_COL_MAJOR_EN
  input  logic                      col_major,
`endif
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [2*FEATURE_BITS-1:0] address_out,
  output logic                      cs_out,
  output logic                      oe_out,
  input  logic [ELEMENT_BITS-1:0]   data_out,
  output logic [ELEMENT_BITS-1:0]   w_data,
  output logic                      w_valid,
  input  logic                      w_ready,
  output logic                      w_row_last,
  output logic                      w_mat_last
);

  localparam int AW = 2*FEATURE_BITS;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = ELEMENT_BITS + 2;
  localparam logic [FEATURE_BITS-1:0] F_ONE = FEATURE_BITS'(1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FINISH} state_t;

  state_t                  r_state, w_state_next;
  logic [FEATURE_BITS-1:0] r_m, r_gamma, r_row, r_col;
  logic [FEATURE_BITS-1:0] w_row_next, w_col_next;
  logic [AW-1:0]           r_addr, w_addr_next;
`ifdef DPR_W_I_READER_COL_MAJOR_EN
  logic                    r_col_major;
  logic [AW-1:0]           r_row_base, w_base_next;
`endif

  logic                    r_inflight, r_if_row_last, r_if_mat_last;
  logic [EW-1:0]           r_fifo [FIFO_DEPTH];
  logic [PW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]           r_count;

  logic                    w_pop, w_push, w_issue, w_credit_ok;
  logic                    w_empty_mat, w_row_end, w_col_end, w_last, w_tag_row_last;
  logic [CW:0]             w_occ, w_limit;
  logic [EW-1:0]           w_head;

  assign w_empty_mat = (r_m == '0) || (r_gamma == '0);
  assign w_row_end   = (r_row == r_gamma - F_ONE);
  assign w_col_end   = (r_col == r_m - F_ONE);
  assign w_last      = w_row_end && w_col_end;
`ifdef DPR_W_I_READER_COL_MAJOR_EN
  assign w_tag_row_last = r_col_major ? w_row_end : w_col_end;
`else
  assign w_tag_row_last = w_col_end;
`endif

  // Credit: buffered + in-flight elements after this cycle's pop must leave room for one more.
  assign w_pop       = w_valid && w_ready;
  assign w_push      = r_inflight;
  assign w_occ       = {1'b0, r_count} + (CW+1)'(r_inflight);
  assign w_limit     = (CW+1)'(FIFO_DEPTH) + (CW+1)'(w_pop);
  assign w_credit_ok = (w_occ < w_limit);
  assign w_issue     = (r_state == S_FETCH) && !w_empty_mat && w_credit_ok;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_FETCH;
      S_FETCH: begin
        if (w_empty_mat)
          w_state_next = S_FINISH;
        else if (w_issue && w_last)
          w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r_inflight && ((r_count == '0) || ((r_count == CW'(1)) && w_pop)))
          w_state_next = S_FINISH;
      end
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_row_next  = r_row;
    w_col_next  = r_col;
    w_addr_next = r_addr + AW'(1);
`ifdef DPR_W_I_READER_COL_MAJOR_EN
    w_base_next = r_row_base;
    // Column-major keeps row*m in a running base so the address needs only adders.
    if (r_col_major) begin
      if (w_row_end) begin
        w_row_next  = '0;
        w_col_next  = r_col + F_ONE;
        w_base_next = '0;
        w_addr_next = AW'(r_col) + AW'(1);
      end else begin
        w_row_next  = r_row + F_ONE;
        w_base_next = r_row_base + AW'(r_m);
        w_addr_next = r_row_base + AW'(r_m) + AW'(r_col);
      end
    end else begin
`else
    begin
`endif
      if (w_col_end) begin
        w_col_next = '0;
        w_row_next = r_row + F_ONE;
      end else begin
        w_col_next = r_col + F_ONE;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_m     <= '0;
      r_gamma <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_addr  <= '0;
`ifdef DPR_W_I_READER_COL_MAJOR_EN
      r_col_major <= 1'b0;
      r_row_base  <= '0;
`endif
    end else if ((r_state == S_IDLE) && start) begin
      r_m     <= m;
      r_gamma <= gamma;
      r_row   <= '0;
      r_col   <= '0;
      r_addr  <= '0;
`ifdef DPR_W_I_READER_COL_MAJOR_EN
      r_col_major <= col_major;
      r_row_base  <= '0;
`endif
    end else if (w_issue) begin
      r_row  <= w_row_next;
      r_col  <= w_col_next;
      r_addr <= w_addr_next;
`ifdef DPR_W_I_READER_COL_MAJOR_EN
      r_row_base <= w_base_next;
`endif
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_inflight    <= 1'b0;
      r_if_row_last <= 1'b0;
      r_if_mat_last <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      r_inflight    <= w_issue;
      r_if_row_last <= w_issue && w_tag_row_last;
      r_if_mat_last <= w_issue && w_last;
      if (w_push) begin
        r_fifo[r_wr_ptr] <= {r_if_mat_last, r_if_row_last, data_out};
        r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : r_rd_ptr + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - CW'(1);
    end
  end

  assign w_head      = r_fifo[r_rd_ptr];
  assign w_valid     = (r_count != '0);
  assign w_data      = w_head[ELEMENT_BITS-1:0];
  assign w_row_last  = w_head[ELEMENT_BITS];
  assign w_mat_last  = w_head[ELEMENT_BITS+1];
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_FINISH);
  assign cs_out      = w_issue;
  assign oe_out      = w_issue;
  assign address_out = r_addr;

endmodule

// File: tb/tb_dpr_w_i_reader.sv
// Scoreboard bench for dpr_w_i_reader: RAM model, randomized runs, backpressure, restart, mid-run reset.
module tb_dpr_w_i_reader;

  logic       sys_clk = 1'b0;
  logic       reset_n;
  logic [3:0] m, gamma;
  logic       start;
  logic       busy, done, cs_out, oe_out;
  logic [7:0] address_out;
  logic [7:0] data_out;
  logic [7:0] w_data;
  logic       w_valid;
  logic       w_ready = 1'b1;
  logic       w_row_last, w_mat_last;
`ifdef DPR_W_I_READER_COL_MAJOR_EN
  logic       col_major = 1'b0;
`endif

  dpr_w_i_reader #(.FEATURE_BITS(4), .ELEMENT_BITS(8), .FIFO_DEPTH(2)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .m(m), .gamma(gamma),
`ifdef DPR_W_I_READER_COL_MAJOR_EN
    .col_major(col_major),
`endif
    .start(start), .busy(busy), .done(done), .address_out(address_out),
    .cs_out(cs_out), .oe_out(oe_out), .data_out(data_out), .w_data(w_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_row_last(w_row_last), .w_mat_last(w_mat_last)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0, passes = 0;
  int cyc = 0;
  int t_start = 0;
  int exp_done_cyc = -1;
  int issued = 0, beats_done = 0;
  int rdy_mode = 0, stall_cnt = 0;
  bit in_reset = 1'b0;
  bit first_cs_pending = 1'b0, first_valid_pending = 1'b0;
  bit prev_hold = 1'b0;
  logic [9:0] prev_payload;
  logic [7:0] ram [256];
  logic [7:0] addr_q [$];
  logic [9:0] beat_q [$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  // RAM read port: data valid the cycle after a read, garbage otherwise.
  always @(posedge sys_clk) begin
    if (cs_out && oe_out) data_out <= ram[address_out];
    else                  data_out <= 8'($urandom);
  end

  always @(posedge sys_clk) begin
    #1;
    if (stall_cnt > 0) begin
      w_ready = 1'b0;
      stall_cnt = stall_cnt - 1;
    end else if (rdy_mode == 1) w_ready = 1'($urandom);
    else w_ready = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Reference order: plain nested loops over the matrix, address = row*m + col.
  task automatic push_expect(input int mm, input int gg, input bit cm);
    int r, c, a;
    if (mm == 0 || gg == 0) return;
    for (int o = 0; o < (cm ? mm : gg); o++) begin
      for (int i = 0; i < (cm ? gg : mm); i++) begin
        r = cm ? i : o;
        c = cm ? o : i;
        a = r * mm + c;
        addr_q.push_back(8'(a));
        beat_q.push_back({ram[a], (cm ? (r == gg-1) : (c == mm-1)), (r == gg-1 && c == mm-1)});
      end
    end
  endtask

  task automatic do_start(input int mm, input int gg, input bit cm);
    @(posedge sys_clk); #1;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    m = 4'(mm); gamma = 4'(gg); start = 1'b1;
`ifdef DPR_W_I_READER_COL_MAJOR_EN
    col_major = cm;
`endif
    t_start = cyc;
    issued = 0; beats_done = 0;
    push_expect(mm, gg, cm);
    first_cs_pending    = (mm != 0 && gg != 0);
    first_valid_pending = (mm != 0 && gg != 0);
    exp_done_cyc        = (mm == 0 || gg == 0) ? t_start + 2 : -1;
    $display("run m=%0d gamma=%0d col_major=%0d ready_mode=%0d beats=%0d", mm, gg, cm, rdy_mode, beat_q.size());
    @(posedge sys_clk); #1;
    start = 1'b0; m = 4'($urandom); gamma = 4'($urandom);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge sys_clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk("done_seen", 32'(seen), 32'd1);
    @(negedge sys_clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("all_delivered", 32'(beat_q.size() + addr_q.size()), 32'd0);
  endtask

  task automatic wait_beats(input int n);
    bit seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge sys_clk);
      if (beats_done >= n) begin seen = 1'b1; break; end
    end
    chk("beat_progress", 32'(seen), 32'd1);
  endtask

  task automatic check_zero_outputs(input string name);
    chk(name, {15'd0, busy, done, cs_out, oe_out, w_valid, w_row_last, w_mat_last, address_out, w_data}, 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues a read or completes a handshake.
  always @(negedge sys_clk) begin
    if (in_reset) begin
      prev_hold = 1'b0;
    end else begin
      if (cs_out || oe_out) begin
        if (addr_q.size() == 0) chk("unexpected_read", {24'd0, address_out}, 32'hFFFF_FFFF);
        else chk("read_addr", {22'd0, oe_out, cs_out, address_out}, {22'd0, 2'b11, addr_q.pop_front()});
        if (first_cs_pending) begin
          chk("first_read_cycle", 32'(cyc), 32'(t_start + 1));
          first_cs_pending = 1'b0;
        end
        issued++;
      end
      if (prev_hold)
        chk("stall_stable", {21'd0, w_valid, w_data, w_row_last, w_mat_last}, {21'd0, 1'b1, prev_payload});
      if (w_valid && first_valid_pending) begin
        chk("first_valid_cycle", 32'(cyc), 32'(t_start + 3));
        first_valid_pending = 1'b0;
      end
      if (w_valid && w_ready) begin
        if (beat_q.size() == 0) chk("unexpected_beat", {24'd0, w_data}, 32'hFFFF_FFFF);
        else chk("beat", {22'd0, w_data, w_row_last, w_mat_last}, {22'd0, beat_q.pop_front()});
        beats_done++;
        if (w_mat_last) exp_done_cyc = cyc + 1;
        if (rdy_mode == 2 && beats_done == 4) stall_cnt = 5;
      end
      if (cs_out) chk("outstanding_le_2", 32'(issued - beats_done <= 2), 32'd1);
      if (done || cyc == exp_done_cyc) chk("done_cycle", 32'(done), 32'(cyc == exp_done_cyc));
      prev_hold    = w_valid && !w_ready;
      prev_payload = {w_data, w_row_last, w_mat_last};
    end
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; m = '0; gamma = '0;
    in_reset = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 reset_n = 1'b1;
    @(negedge sys_clk);
    check_zero_outputs("reset_outputs");
    in_reset = 1'b0;

    rdy_mode = 0;
    do_start(9, 3, 1'b0);
    wait_done();

    rdy_mode = 2;
    do_start(9, 3, 1'b0);
    wait_done();
    rdy_mode = 0;

    do_start(0, 3, 1'b0);
    @(negedge sys_clk); chk("empty_busy_t1", 32'(busy), 32'd1);
    @(negedge sys_clk); chk("empty_busy_t2", 32'(busy), 32'd1);
    @(negedge sys_clk); chk("empty_busy_t3", 32'(busy), 32'd0);

    do_start(5, 0, 1'b0);
    @(negedge sys_clk); @(negedge sys_clk); @(negedge sys_clk);
    chk("empty_gamma_busy", 32'(busy), 32'd0);

    do_start(9, 3, 1'b0);
    wait_beats(6);
    @(posedge sys_clk); #1 start = 1'b1; m = 4'd4; gamma = 4'($urandom);
    @(posedge sys_clk); #1 start = 1'b0;
    wait_done();

    do_start(9, 3, 1'b0);
    wait_beats(11);
    @(posedge sys_clk); #1;
    reset_n = 1'b0; in_reset = 1'b1;
    addr_q.delete(); beat_q.delete();
    first_cs_pending = 1'b0; first_valid_pending = 1'b0; exp_done_cyc = -1;
    @(posedge sys_clk); #1 reset_n = 1'b1;
    @(negedge sys_clk);
    check_zero_outputs("midrun_reset_outputs");
    in_reset = 1'b0;
    do_start(9, 3, 1'b0);
    wait_done();

    rdy_mode = 1;
    do_start(1, 4, 1'b0);
    wait_done();
    for (int k = 0; k < 8; k++) begin
      do_start($urandom_range(1, 15), $urandom_range(1, 15), 1'b0);
      wait_done();
    end

`ifdef DPR_W_I_READER_COL_MAJOR_EN
    rdy_mode = 0;
    do_start(3, 2, 1'b1);
    wait_done();
    rdy_mode = 1;
    for (int k = 0; k < 4; k++) begin
      do_start($urandom_range(1, 15), $urandom_range(1, 15), 1'($urandom));
      wait_done();
    end
`endif

    repeat (3) @(negedge sys_clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
